// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern transmitter.
//   - tx_state_t   : transmitter FSM states (IDLE, SHIFT, GAP)
//   - DEF_*        : default pattern width and clocks-per-bit
//   - LED_W        : width of the LED mirror of transmitted bits
//   - rep_cnt_t    : 4-bit repetition count type
//   - rep_inc_sat  : saturating increment for the repetition counter
package seq_pkg;

    localparam int DEF_PATTERN_W  = 8;
    localparam int DEF_BIT_CYCLES = 67108864;
    localparam int LED_W          = 8;

    typedef logic [3:0] rep_cnt_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } tx_state_t;

    function automatic rep_cnt_t rep_inc_sat(input rep_cnt_t v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/seq_bit_tick.sv
// Bit-period prescaler.
// Counts 0..BIT_CYCLES-1 while enabled and emits a one-cycle wrap pulse on
// the last count of every bit period.
//   clk      in  system clock
//   rst      in  synchronous active-high reset
//   clear    in  synchronous clear of the count (held while transmitter idle)
//   enable   in  advance the count
//   wrap     out high in the last cycle of a bit period
//   at_start out high while the count is 0 (first cycle of a bit period)
module seq_bit_tick #(
    parameter int BIT_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic wrap,
    output logic at_start
);

    localparam int CW = $clog2(BIT_CYCLES);

    logic [CW-1:0] count_reg;

    assign wrap     = enable && (count_reg == CW'(BIT_CYCLES - 1));
    assign at_start = (count_reg == '0);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (enable) begin
            count_reg <= wrap ? '0 : count_reg + CW'(1);
        end
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: accepts a PATTERN_W-bit word on a valid/ready
// load port and sends it MSB-first on ser_out, one bit per BIT_CYCLES clocks,
// repeat_cnt times (0 = until stop). The last eight sent bits are mirrored
// on LED (newest in LED[0]).
// Build option: define SEQ_TX_GAP_EN to insert one idle 0 bit between
// consecutive repetitions (never after the final one).
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   load_valid/ready   load handshake (ready only while idle)
//   load_data          pattern to send
//   repeat_cnt         repetitions, 0 = continuous
//   stop               level request to end after the current repetition
//   ser_out            serial data, 0 when idle / in the gap
//   bit_strobe         pulse in the first cycle of each data bit
//   busy, done         transmission active / completion pulse
//   LED                shift register of transmitted bits
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int BIT_CYCLES = DEF_BIT_CYCLES,
    parameter int PATTERN_W  = DEF_PATTERN_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_valid,
    output logic                 load_ready,
    input  logic [PATTERN_W-1:0] load_data,
    input  rep_cnt_t             repeat_cnt,
    input  logic                 stop,
    output logic                 ser_out,
    output logic                 bit_strobe,
    output logic                 busy,
    output logic                 done,
    output logic [LED_W-1:0]     LED
);

    localparam int IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;

    tx_state_t            state_reg, state_next;
    logic [PATTERN_W-1:0] shift_reg;
    logic [PATTERN_W-1:0] shift_rot;
    logic [IDX_W-1:0]     bit_idx_reg;
    rep_cnt_t             repeat_reg;
    rep_cnt_t             rep_done_reg;
    rep_cnt_t             rep_after;
    logic                 stop_pending_reg;
    logic [LED_W-1:0]     led_reg;
    logic                 done_reg;

    logic wrap, at_start;
    logic last_bit, rep_end, stop_eff, final_rep;

    seq_bit_tick #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_tick (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_reg == IDLE),
        .enable  (state_reg != IDLE),
        .wrap    (wrap),
        .at_start(at_start)
    );

    // The pattern is rotated rather than shifted out so that after a full
    // repetition it is back in its original order for the next one.
    generate
        if (PATTERN_W == 1) begin : g_rot1
            assign shift_rot = shift_reg;
        end else begin : g_rotn
            assign shift_rot = {shift_reg[PATTERN_W-2:0], shift_reg[PATTERN_W-1]};
        end
    endgenerate

    assign last_bit  = (bit_idx_reg == IDX_W'(PATTERN_W - 1));
    assign rep_end   = (state_reg == SHIFT) && wrap && last_bit;
    // A stop arriving in the very cycle a decision is made still counts.
    assign stop_eff  = stop_pending_reg || stop;
    assign rep_after = rep_inc_sat(rep_done_reg);
    assign final_rep = (repeat_reg != 4'd0) && (rep_after == repeat_reg);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (load_valid) state_next = SHIFT;
            end
            SHIFT: begin
                if (rep_end) begin
                    if (final_rep || stop_eff) begin
                        state_next = IDLE;
                    end else begin
`ifdef SEQ_TX_GAP_EN
                        state_next = GAP;
`else
                        state_next = SHIFT;
`endif
                    end
                end
            end
`ifdef SEQ_TX_GAP_EN
            GAP: begin
                if (wrap) state_next = stop_eff ? IDLE : SHIFT;
            end
`endif
            default: state_next = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        load_ready = (state_reg == IDLE);
        busy       = (state_reg != IDLE);
        ser_out    = (state_reg == SHIFT) ? shift_reg[PATTERN_W-1] : 1'b0;
        bit_strobe = (state_reg == SHIFT) && at_start;
        done       = done_reg;
        LED        = led_reg;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg        <= '0;
            bit_idx_reg      <= '0;
            repeat_reg       <= '0;
            rep_done_reg     <= '0;
            stop_pending_reg <= 1'b0;
            led_reg          <= '0;
            done_reg         <= 1'b0;
        end else begin
            done_reg <= (state_reg != IDLE) && (state_next == IDLE);

            if (state_reg == IDLE) begin
                if (load_valid) begin
                    shift_reg        <= load_data;
                    repeat_reg       <= repeat_cnt;
                    rep_done_reg     <= '0;
                    bit_idx_reg      <= '0;
                    stop_pending_reg <= 1'b0;
                end
            end else if (stop) begin
                stop_pending_reg <= 1'b1;
            end

            if ((state_reg == SHIFT) && wrap) begin
                shift_reg   <= shift_rot;
                bit_idx_reg <= last_bit ? '0 : bit_idx_reg + IDX_W'(1);
                if (last_bit) rep_done_reg <= rep_after;
            end

            if (bit_strobe) begin
                led_reg <= {led_reg[LED_W-2:0], shift_reg[PATTERN_W-1]};
            end
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Randomized self-checking bench for seq_pattern_tx (BIT_CYCLES=4, PATTERN_W=8).
// Expected waveforms are generated per transaction from the bit timing rules.
module tb_seq_pattern_tx;
    import seq_pkg::*;

    localparam int BC = 4;
    localparam int PW = 8;
`ifdef SEQ_TX_GAP_EN
    localparam bit GAP_EN = 1'b1;
`else
    localparam bit GAP_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          load_valid;
    logic          load_ready;
    logic [PW-1:0] load_data;
    rep_cnt_t      repeat_cnt;
    logic          stop;
    logic          ser_out;
    logic          bit_strobe;
    logic          busy;
    logic          done;
    logic [7:0]    LED;

    seq_pattern_tx #(
        .BIT_CYCLES(BC),
        .PATTERN_W (PW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load_valid(load_valid),
        .load_ready(load_ready),
        .load_data (load_data),
        .repeat_cnt(repeat_cnt),
        .stop      (stop),
        .ser_out   (ser_out),
        .bit_strobe(bit_strobe),
        .busy      (busy),
        .done      (done),
        .LED       (LED)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit ser;
        bit stb;
        bit bsy;
        bit dn;
    } cyc_t;

    cyc_t       exp_q[$];
    logic [7:0] led_model;
    int         period;

    // Expected per-cycle outputs from the cycle after the load edge up to and
    // including the done cycle.
    task automatic build(input logic [PW-1:0] pat, input int rc, input int stop_at);
        int   stop_rep;
        int   nreps;
        bit   stop_in_gap;
        cyc_t c;
        exp_q.delete();
        stop_rep    = 1 << 20;
        stop_in_gap = 1'b0;
        if (stop_at > 0) begin
            stop_rep    = (stop_at - 1) / period;
            stop_in_gap = ((stop_at - 1) % period) >= PW * BC;
        end
        nreps = stop_rep + 1;
        if (rc != 0 && rc < nreps) nreps = rc;
        for (int r = 0; r < nreps; r++) begin
            for (int k = 0; k < PW; k++) begin
                for (int j = 0; j < BC; j++) begin
                    c.ser = pat[PW-1-k];
                    c.stb = (j == 0);
                    c.bsy = 1'b1;
                    c.dn  = 1'b0;
                    exp_q.push_back(c);
                end
            end
            if (GAP_EN && (r < nreps - 1 ||
                           (r == stop_rep && stop_in_gap && (rc == 0 || r < rc - 1)))) begin
                for (int j = 0; j < BC; j++) begin
                    c.ser = 1'b0; c.stb = 1'b0; c.bsy = 1'b1; c.dn = 1'b0;
                    exp_q.push_back(c);
                end
            end
        end
        c.ser = 1'b0; c.stb = 1'b0; c.bsy = 1'b0; c.dn = 1'b1;
        exp_q.push_back(c);
    endtask

    // Entered at a negedge with the DUT idle (or in its done cycle).
    task automatic run_tx(input logic [PW-1:0] pat, input int rc, input int stop_at,
                          input int rst_at, input bit hold_next);
        cyc_t c;
        int   n;
        check_val("load_ready_before_load", load_ready, 1);
        build(pat, rc, stop_at);
        n          = exp_q.size();
        load_valid = 1'b1;
        load_data  = pat;
        repeat_cnt = 4'(rc);
        for (int o = 1; o <= n; o++) begin
            @(posedge clk);
            @(negedge clk);
            if (o == 1) begin
                if (hold_next) begin
                    load_data = 8'h55;
                end else begin
                    load_valid = 1'b0;
                    load_data  = PW'($urandom);
                end
                repeat_cnt = 4'($urandom);
            end
            c = exp_q[o-1];
            check_val("ser_out", ser_out, c.ser);
            check_val("bit_strobe", bit_strobe, c.stb);
            check_val("busy", busy, c.bsy);
            check_val("done", done, c.dn);
            check_val("load_ready", load_ready, c.dn);
            check_val("LED", LED, led_model);
            if (c.stb) led_model = {led_model[6:0], c.ser};
            stop = (stop_at > 0) && (o >= stop_at) && (o < n);
            if (rst_at > 0 && o == rst_at) begin
                rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                check_val("rst_ser_out", ser_out, 0);
                check_val("rst_busy", busy, 0);
                check_val("rst_LED", LED, 0);
                check_val("rst_load_ready", load_ready, 1);
                check_val("rst_done", done, 0);
                check_val("rst_bit_strobe", bit_strobe, 0);
                rst        = 1'b0;
                stop       = 1'b0;
                load_valid = 1'b0;
                led_model  = '0;
                $display("tx pat=%02h rep=%0d stop_at=%0d reset at %0d", pat, rc, stop_at, rst_at);
                return;
            end
        end
        stop = 1'b0;
        $display("tx pat=%02h rep=%0d stop_at=%0d cycles=%0d LED=%02h", pat, rc, stop_at, n, LED);
    endtask

    task automatic idle_cycles(input int n);
        load_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            stop = 1'($urandom_range(0, 1));
            @(posedge clk);
            @(negedge clk);
            check_val("idle_ser_out", ser_out, 0);
            check_val("idle_busy", busy, 0);
            check_val("idle_done", done, 0);
            check_val("idle_load_ready", load_ready, 1);
            check_val("idle_LED", LED, led_model);
        end
        stop = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat, rc, stop_at, rst_at;
        bit hold;
        period     = PW * BC + (GAP_EN ? BC : 0);
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        repeat_cnt = '0;
        stop       = 1'b0;
        led_model  = '0;
        @(negedge clk);
        @(negedge clk);
        check_val("reset_ser_out", ser_out, 0);
        check_val("reset_bit_strobe", bit_strobe, 0);
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_LED", LED, 0);
        check_val("reset_load_ready", load_ready, 1);
        rst = 1'b0;
        idle_cycles(2);

        run_tx(8'hB9, 1, 0, 0, 1'b0);
        check_val("led_after_b9", LED, 8'hB9);
        idle_cycles(3);
        run_tx(8'hF0, 0, 40, 0, 1'b0);
        idle_cycles(2);
        run_tx(8'hA5, 1, 0, 0, 1'b1);
        run_tx(8'h55, 1, 0, 0, 1'b0);
        idle_cycles(2);
        run_tx(8'hC3, 2, 0, 10, 1'b0);
        idle_cycles(3);
        run_tx(8'hB9, 2, 0, 0, 1'b0);
        idle_cycles(2);
        run_tx(8'h81, 3, 0, 0, 1'b0);
        idle_cycles(2);

        for (int t = 0; t < 16; t++) begin
            pat     = int'($urandom_range(0, 255));
            rc      = int'($urandom_range(0, 4));
            stop_at = 0;
            if (rc == 0) begin
                stop_at = int'($urandom_range(1, 3 * period));
            end else if ($urandom_range(0, 3) == 0) begin
                stop_at = int'($urandom_range(1, rc * period));
            end
            rst_at = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 20)) : 0;
            hold   = ($urandom_range(0, 3) == 0) && (rst_at == 0);
            run_tx(8'(pat), rc, stop_at, rst_at, hold);
            if (!hold) idle_cycles(int'($urandom_range(1, 3)));
        end
        idle_cycles(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
